// File: rtl/bias_sequencer.sv
// Per-lane bias stage sequencer: walks a feature map channel by channel, adding the
// channel's bias vector to each activation lane and halving the 9-bit sum.
module bias_sequencer #(
  parameter int unsigned SIZE     = 4,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned PIXELS   = 16,
  localparam int unsigned AW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned PW      = (PIXELS > 1) ? $clog2(PIXELS) : 1,
  localparam int unsigned W       = 8 * SIZE
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          bias_wr_en,
  input  logic [AW-1:0] bias_wr_addr,
  input  logic [W-1:0]  bias_wr_data,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic [1:0]    state_dbg
);

  // Handshake rule on both ports: a transfer happens on a rising edge where valid
  // and ready are both high; valid never depends on ready, in_ready depends on out_*.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [AW-1:0] CH_LAST  = AW'(CHANNELS - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(PIXELS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] chan_q;
  logic [PW-1:0] pix_q;
  logic [W-1:0]  bias_mem [CHANNELS];
  logic [W-1:0]  bias_sel;
  logic [W-1:0]  comb_data;
  logic          accept;
  logic          last_beat;
  logic          out_hs;

  assign bias_sel  = bias_mem[chan_q];
  assign last_beat = (chan_q == CH_LAST) && (pix_q == PIX_LAST);
  assign out_hs    = out_valid & out_ready;
  assign accept    = (state_q == RUN) & in_valid & in_ready;
  assign state_dbg = state_q;

  // Lane sum kept at 9 bits so the halving never loses the carry.
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic [8:0] lane_sum;
    assign lane_sum            = {1'b0, in_data[8*i +: 8]} + {1'b0, bias_sel[8*i +: 8]};
    assign comb_data[8*i +: 8] = lane_sum[8:1];
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = ~out_valid | out_ready;
        if (in_valid && in_ready && last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (out_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      chan_q    <= '0;
      pix_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == DRAIN) && out_hs;

      if (state_q == IDLE && start) begin
        chan_q <= '0;
        pix_q  <= '0;
      end else if (accept) begin
        if (pix_q == PIX_LAST) begin
          pix_q  <= '0;
          chan_q <= (chan_q == CH_LAST) ? '0 : chan_q + AW'(1);
        end else begin
          pix_q <= pix_q + PW'(1);
        end
      end

      // A new accept wins over a plain drain so back-to-back beats keep out_valid high.
      if (accept) begin
        out_data  <= comb_data;
        out_valid <= 1'b1;
        out_last  <= last_beat;
      end else if (out_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < int'(CHANNELS); c++) bias_mem[c] <= '0;
    end else if (state_q == IDLE && bias_wr_en && 32'(bias_wr_addr) < CHANNELS) begin
      bias_mem[bias_wr_addr] <= bias_wr_data;
    end
  end

endmodule

// File: tb/tb_bias_sequencer.sv
// Directed bench for bias_sequencer with a 2-channel, 2-pixel map and hand-computed outputs.
module tb_bias_sequencer;

  localparam int SIZE = 4;
  localparam int CHANNELS = 2;
  localparam int PIXELS = 2;
  localparam int W = 8 * SIZE;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         bias_wr_en = 1'b0;
  logic [0:0]   bias_wr_addr = '0;
  logic [W-1:0] bias_wr_data = '0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [W:0] exp_q[$];

  bias_sequencer #(.SIZE(SIZE), .CHANNELS(CHANNELS), .PIXELS(PIXELS)) dut (
    .clock(clock), .reset(reset),
    .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
    .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] vec(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks: all entered and left at posedge + 1
  task automatic write_bias(input logic [0:0] addr, input logic [W-1:0] data);
    bias_wr_en = 1'b1; bias_wr_addr = addr; bias_wr_data = data;
    @(posedge clock); #1;
    bias_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] e, input logic l, output int n);
    n = 0;
    in_data = d;
    in_valid = 1'b1;
    do begin
      @(negedge clock);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      check("accept_timeout", {32'd0, in_ready}, 33'd1);
      @(posedge clock); #1;
    end else begin
      exp_q.push_back({l, e});
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  // scoreboard: output handshakes are decided at the next edge; inputs are stable here
  always @(negedge clock) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        check("exp_pending", {32'd0, exp_q.size() != 0}, 33'd1);
        if (exp_q.size() != 0) check("out_beat", {out_last, out_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int n;
    int waited;

    #1 reset = 1'b1;
    #2;
    check("rst_in_ready", {32'd0, in_ready}, 33'd0);
    check("rst_out_valid", {32'd0, out_valid}, 33'd0);
    check("rst_out", {out_last, out_data}, 33'd0);
    check("rst_busy_done", {31'd0, busy, done}, 33'd0);
    check("rst_state", {31'd0, state_dbg}, 33'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // map A
    write_bias(1'b0, vec(1, 2, 3, 4));
    write_bias(1'b1, vec(127, 128, 200, 255));

    in_valid = 1'b1; in_data = vec(9, 9, 9, 9);
    repeat (3) begin
      @(negedge clock);
      check("idle_in_ready", {32'd0, in_ready}, 33'd0);
    end
    check("idle_out_valid", {32'd0, out_valid}, 33'd0);
    @(posedge clock); #1;
    in_valid = 1'b0;

    pulse_start();
    @(negedge clock);
    check("run_state", {31'd0, state_dbg}, 33'd1);
    check("run_busy", {32'd0, busy}, 33'd1);
    @(posedge clock); #1;

    send(vec(31, 28, 53, 94), vec(16, 15, 28, 49), 1'b0, n);

    // writes and start during RUN must be ignored
    start = 1'b1; bias_wr_en = 1'b1; bias_wr_addr = 1'b0; bias_wr_data = '1;
    @(posedge clock); #1;
    start = 1'b0; bias_wr_en = 1'b0;
    @(negedge clock);
    check("run_start_ignored", {31'd0, state_dbg}, 33'd1);
    @(posedge clock); #1;

    send(vec(1, 2, 3, 4), vec(1, 2, 3, 4), 1'b0, n);
    @(posedge clock); #1;

    out_ready = 1'b0;
    send(vec(128, 128, 200, 255), vec(127, 128, 200, 255), 1'b0, n);
    repeat (3) begin
      @(negedge clock);
      check("stall_out", {out_last, out_data}, {1'b0, vec(127, 128, 200, 255)});
      check("stall_valid", {32'd0, out_valid}, 33'd1);
      check("stall_in_ready", {32'd0, in_ready}, 33'd0);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    send(vec(255, 255, 255, 255), vec(191, 191, 227, 255), 1'b1, n);

    out_ready = 1'b0;
    pulse_start();
    @(negedge clock);
    check("drain_state", {31'd0, state_dbg}, 33'd2);
    check("drain_out", {out_last, out_data}, {1'b1, vec(191, 191, 227, 255)});
    check("drain_done_low", {32'd0, done}, 33'd0);
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("done_pulse", {32'd0, done}, 33'd1);
    check("done_busy", {32'd0, busy}, 33'd0);
    check("done_state", {31'd0, state_dbg}, 33'd0);
    @(negedge clock);
    check("done_one_cycle", {32'd0, done}, 33'd0);
    check("idle_after_drain_start", {31'd0, state_dbg}, 33'd0);
    check("mapa_done_cnt", 33'(done_cnt), 33'd1);
    @(posedge clock); #1;

    // map B: start together with a bias write, then full-rate streaming
    start = 1'b1; bias_wr_en = 1'b1; bias_wr_addr = 1'b1; bias_wr_data = '1;
    @(posedge clock); #1;
    start = 1'b0; bias_wr_en = 1'b0;
    send(vec(31, 28, 53, 94), vec(16, 15, 28, 49), 1'b0, n);
    check("tput_1", 33'(n), 33'd1);
    send(vec(200, 100, 50, 0), vec(100, 51, 26, 2), 1'b0, n);
    check("tput_2", 33'(n), 33'd1);
    send(vec(255, 255, 255, 255), vec(255, 255, 255, 255), 1'b0, n);
    check("tput_3", 33'(n), 33'd1);
    send(vec(0, 1, 2, 3), vec(127, 128, 128, 129), 1'b1, n);
    check("tput_4", 33'(n), 33'd1);
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!done && waited < 10);
    check("mapb_done", {32'd0, done}, 33'd1);
    @(posedge clock); #1;
    check("mapb_done_cnt", 33'(done_cnt), 33'd2);

    // reset mid-map
    pulse_start();
    send(vec(10, 20, 30, 40), vec(5, 11, 16, 22), 1'b0, n);
    send(vec(0, 0, 0, 0), vec(0, 1, 1, 2), 1'b0, n);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", {32'd0, out_valid}, 33'd0);
    check("mid_rst_out", {out_last, out_data}, 33'd0);
    check("mid_rst_flags", {30'd0, in_ready, busy, done}, 33'd0);
    check("mid_rst_state", {31'd0, state_dbg}, 33'd0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    pulse_start();
    send(vec(10, 20, 30, 40), vec(5, 10, 15, 20), 1'b0, n);
    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(negedge clock);
      waited++;
    end
    check("post_rst_drained", 33'(exp_q.size()), 33'd0);
    check("post_rst_done_cnt", 33'(done_cnt), 33'd2);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bias_sequencer.md
# bias_sequencer

Controller that sequences the per-lane bias stage over a full feature map. It holds one SIZE-lane bias vector per output channel and streams activation vectors through a registered lane combiner with valid/ready handshakes on both sides. It selects the bias vector for the current channel and counts pixels and channels, and it reports when the map is complete. It sits between the convolution/accumulate output and the next layer.

## Interface
- SIZE, 4, lanes per vector; each lane is 8-bit unsigned, lane i = bits [8i+7:8i]
- CHANNELS, 8, number of channels and bias vectors (≥1)
- PIXELS, 16, vectors per channel (≥1)

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- bias_wr_en  in  1  write a bias vector; honoured only in IDLE
- bias_wr_addr  in  clog2(CHANNELS)  channel index to write; out-of-range writes are dropped
- bias_wr_data  in  8*SIZE  bias vector
- start  in  1  single-cycle pulse; begins a map in IDLE, ignored elsewhere
- in_valid  in  1  activation vector valid
- in_ready  out  1  block can accept in_data
- in_data  in  8*SIZE  activation vector
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_data  out  8*SIZE  biased vector
- out_last  out  1  with out_valid, marks the final vector of the map
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when the last vector is consumed

## Operation
- Lane arithmetic: out lane = (in lane + bias lane) >> 1, with a 9-bit intermediate truncated to 8 bits. Each lane is unsigned and independent, with no overflow and no saturation.
- Bias memory: CHANNELS × 8*SIZE registers, cleared to 0 by reset. Contents persist across maps.
- FSM states:
  - IDLE: busy=0 and in_ready=0. Bias writes are accepted. start → RUN, with chan=0 and pix=0.
  - RUN: in_ready = ~out_valid | out_ready.
    - Accept = in_valid & in_ready. On accept, the out register loads in_data combined with bias_mem[chan], and out_valid=1.
    - out_last=1 when the accepted vector is at chan=CHANNELS-1 and pix=PIXELS-1.
    - pix increments on each accept. When pix=PIXELS-1 it wraps to 0 and chan increments.
    - The accept of the final vector → DRAIN.
  - DRAIN: in_ready=0. When out_valid & out_ready → IDLE, done=1 for one cycle, out_valid=0, out_last=0.
- In RUN, an output handshake without a new accept clears out_valid and out_last.
- A simultaneous output handshake and new accept holds out_valid=1 and loads the new data, so the block sustains full throughput.
- bias_wr_en outside IDLE is ignored. A start coincident with bias_wr_en in IDLE performs both actions, and the write lands before the first accept.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0. Counters are 0, state is IDLE, and the bias memory is 0.
- Reset asserted mid-map aborts immediately: all outputs and the bias memory go to their reset values, and no done is issued.
- start at edge N → RUN at N+1. in_ready may be high in the cycle after N.
- Latency is 1 cycle: a vector accepted at edge N appears on out_data with out_valid after edge N.
- Stall: while out_valid & ~out_ready, out_data and out_last hold and in_ready=0.
- done asserts in the cycle after the final output handshake edge. busy falls on the same edge.
- Minimum map duration is CHANNELS*PIXELS + 1 cycles from RUN entry to done.

## Test plan
- Basic bias, CHANNELS=2, PIXELS=2:
  - Write bias ch0={1,2,3,4}, pulse start, send {31,28,53,94} → out {16,15,28,49}.
  - Send {1,2,3,4} → out {1,2,3,4}.
- Width boundary, bias ch1={127,128,200,255}: in {128,128,200,255} → out {127,128,200,255}. In {255,255,255,255} with bias 255 → 255 in every lane.
- Channel wrap: with CHANNELS=2, PIXELS=2, send 4 vectors.
  - Vectors 1–2 use ch0 bias and vectors 3–4 use ch1 bias.
  - out_last is high only on vector 4, and done pulses exactly once after it is consumed.
- Backpressure:
  - Hold out_ready=0 for 3 cycles → out_data and out_last stable, in_ready=0.
  - With continuous in_valid and out_ready, one vector passes per cycle with no bubbles.
- Protocol guards:
  - bias_wr_en during RUN does not change results for the current or next map.
  - start during RUN or DRAIN is ignored.
  - In IDLE, in_valid=1 is never accepted.
- Reset mid-map: assert reset after 2 accepts → all outputs are 0 asynchronously and the bias memory reads 0. After a new start, a vector {10,20,30,40} → out {5,10,15,20}.
